// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the text-mode instruction path.
//  - Text opcodes 0x00-0x04. The CPU register file uses the same values.
//  - TEXT_COMMAND sub-codes (CR, LF, BS, HOME).
//  - State encoding of the text instruction engine FSM.
// Optional feature macro: TEXT_SCROLL_EN. When it is defined, the scroll
// states are added to the state enum.
// ---------------------------------------------------------------------------
package vga_text_pkg;

  localparam logic [7:0] OP_TEXT_WRITE    = 8'h00;
  localparam logic [7:0] OP_TEXT_POSITION = 8'h01;
  localparam logic [7:0] OP_TEXT_CLEAR    = 8'h02;
  localparam logic [7:0] OP_GET_TEXT_AT   = 8'h03;
  localparam logic [7:0] OP_TEXT_COMMAND  = 8'h04;

  localparam logic [7:0] CMD_CR   = 8'h0D;
  localparam logic [7:0] CMD_LF   = 8'h0A;
  localparam logic [7:0] CMD_BS   = 8'h08;
  localparam logic [7:0] CMD_HOME = 8'h0C;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DECODE  = 4'd1,
    ST_WRITE   = 4'd2,
    ST_CLEAR   = 4'd3,
    ST_RD_ADDR = 4'd4,
    ST_RD_WAIT = 4'd5,
`ifdef TEXT_SCROLL_EN
    ST_SCR_RD  = 4'd7,
    ST_SCR_WR  = 4'd8,
    ST_SCR_CLR = 4'd9,
`endif
    ST_DONE    = 4'd6
  } text_state_t;

endpackage

// File: rtl/text_instruction_engine_if.sv
// ---------------------------------------------------------------------------
// text_instruction_engine_if
// Instruction handshake between the CPU register file (master) and the text
// instruction engine (slave).
//  instruction/arg0/arg1  : opcode and arguments; they stay stable after a start
//  instruction_start      : phi2-domain start pulse, asynchronous to the engine
//  instruction_busy       : high while a text opcode is executing
//  instruction_finished   : stretched completion flag
//  instruction_error      : error level, cleared by the next accepted start
//  result_0/result_1      : character/attribute returned by GET_TEXT_AT
// ---------------------------------------------------------------------------
interface text_instruction_engine_if;
  logic [7:0] instruction;
  logic [7:0] arg0;
  logic [7:0] arg1;
  logic       instruction_start;
  logic       instruction_busy;
  logic       instruction_finished;
  logic       instruction_error;
  logic [7:0] result_0;
  logic [7:0] result_1;

  modport master (
    output instruction, arg0, arg1, instruction_start,
    input  instruction_busy, instruction_finished, instruction_error, result_0, result_1
  );

  modport slave (
    input  instruction, arg0, arg1, instruction_start,
    output instruction_busy, instruction_finished, instruction_error, result_0, result_1
  );
endinterface

// File: rtl/start_pulse_sync.sv
// ---------------------------------------------------------------------------
// start_pulse_sync
// Two-flop synchronizer for a level or pulse from another clock domain. A
// rising-edge detector follows it. The module produces one clk-wide pulse for
// each rising edge of async_in.
//  clk      in  destination clock
//  reset_n  in  asynchronous, active-low reset
//  async_in in  signal from the foreign domain
//  pulse    out single-cycle pulse on each rising edge of async_in
// ---------------------------------------------------------------------------
module start_pulse_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);
  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= '0;
    else          sync_reg <= {sync_reg[1:0], async_in};
  end

  assign pulse = sync_reg[1] & ~sync_reg[2];
endmodule

// File: rtl/text_instruction_engine.sv
// ---------------------------------------------------------------------------
// text_instruction_engine
// Runs the text-mode opcodes 0x00-0x04 (WRITE, POSITION, CLEAR, GET_TEXT_AT,
// COMMAND). The engine owns the read/write port of the dual-port text RAM. It
// also exports the cursor position so the display can draw the cursor.
// Ports:
//  clk, reset_n  video clock; asynchronous, active-low reset
//  cpu           text_instruction_engine_if.slave (opcode, args, start, status)
//  mem_addr/we/wdata  text RAM port; address = row*COLS+col; data = {attr,char}
//  mem_rdata     RAM read data. It is valid 1 clk after mem_addr.
//  cursor_col/row  current cursor position
// Optional feature macro: TEXT_SCROLL_EN. When it is defined, a row advance
// past the last row scrolls the screen up one row. When it is undefined, the
// row wraps to 0.
// ---------------------------------------------------------------------------
module text_instruction_engine
  import vga_text_pkg::*;
#(
  parameter int         COLS        = 80,
  parameter int         ROWS        = 30,
  parameter int         ADDR_W      = 12,
  parameter int         FIN_STRETCH = 32,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  text_instruction_engine_if.slave   cpu,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_we,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_rdata,
  output logic [6:0]                 cursor_col,
  output logic [4:0]                 cursor_row
);
  localparam int CELLS = COLS * ROWS;
  localparam int FIN_W = $clog2(FIN_STRETCH + 1);
`ifdef TEXT_SCROLL_EN
  localparam int SCROLL_CELLS = COLS * (ROWS - 1);
`endif

  text_state_t       state_reg, state_next;
  logic [7:0]        op_reg, op_next;
  logic [7:0]        arg0_reg, arg0_next;
  logic [7:0]        arg1_reg, arg1_next;
  logic [6:0]        col_reg, col_next;
  logic [4:0]        row_reg, row_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [FIN_W-1:0]  fin_cnt_reg, fin_cnt_next;
  logic              error_reg, error_next;
  logic [7:0]        res0_reg, res0_next;
  logic [7:0]        res1_reg, res1_next;
`ifdef TEXT_SCROLL_EN
  // Attribute of the most recent WRITE or CLEAR. It is used to fill the row
  // that a scroll exposes.
  logic [7:0]        attr_reg, attr_next;
`endif

  logic              start_edge;
  logic              advance_row;
  logic              args_in_range;
  logic [ADDR_W-1:0] cursor_addr;
  logic [ADDR_W-1:0] arg_addr;

  start_pulse_sync u_start_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (cpu.instruction_start),
    .pulse    (start_edge)
  );

  // The address is ADDR_W wide end to end, so the last cell (CELLS-1) is not truncated.
  assign cursor_addr   = ADDR_W'(row_reg) * ADDR_W'(COLS) + ADDR_W'(col_reg);
  assign arg_addr      = ADDR_W'(arg1_reg) * ADDR_W'(COLS) + ADDR_W'(arg0_reg);
  assign args_in_range = (int'(arg0_reg) < COLS) && (int'(arg1_reg) < ROWS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      arg0_reg    <= '0;
      arg1_reg    <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      cnt_reg     <= '0;
      fin_cnt_reg <= '0;
      error_reg   <= 1'b0;
      res0_reg    <= '0;
      res1_reg    <= '0;
`ifdef TEXT_SCROLL_EN
      attr_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      arg0_reg    <= arg0_next;
      arg1_reg    <= arg1_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      cnt_reg     <= cnt_next;
      fin_cnt_reg <= fin_cnt_next;
      error_reg   <= error_next;
      res0_reg    <= res0_next;
      res1_reg    <= res1_next;
`ifdef TEXT_SCROLL_EN
      attr_reg    <= attr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    arg0_next    = arg0_reg;
    arg1_next    = arg1_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    cnt_next     = cnt_reg;
    fin_cnt_next = '0;
    error_next   = error_reg;
    res0_next    = res0_reg;
    res1_next    = res1_reg;
`ifdef TEXT_SCROLL_EN
    attr_next    = attr_reg;
`endif
    advance_row  = 1'b0;
    mem_addr     = cursor_addr;
    mem_we       = 1'b0;
    mem_wdata    = '0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (state_reg == ST_DONE) begin
          if (fin_cnt_reg == FIN_W'(FIN_STRETCH - 1)) state_next = ST_IDLE;
          else fin_cnt_next = fin_cnt_reg + FIN_W'(1);
        end
        // A start edge during DONE ends the stretch. An unknown opcode does nothing else.
        if (start_edge) begin
          state_next = ST_IDLE;
          if (cpu.instruction <= OP_TEXT_COMMAND) begin
            op_next    = cpu.instruction;
            arg0_next  = cpu.arg0;
            arg1_next  = cpu.arg1;
            error_next = 1'b0;
            state_next = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        state_next = ST_DONE;
        case (op_reg)
          OP_TEXT_WRITE: state_next = ST_WRITE;
          OP_TEXT_POSITION: begin
            if (args_in_range) begin
              col_next = arg0_reg[6:0];
              row_next = arg1_reg[4:0];
            end else begin
              error_next = 1'b1;
            end
          end
          OP_TEXT_CLEAR: begin
            cnt_next   = '0;
            state_next = ST_CLEAR;
          end
          OP_GET_TEXT_AT: begin
            if (args_in_range) state_next = ST_RD_ADDR;
            else error_next = 1'b1;
          end
          OP_TEXT_COMMAND: begin
            case (arg0_reg)
              CMD_CR:   col_next = '0;
              CMD_LF:   advance_row = 1'b1;
              CMD_BS:   if (col_reg != '0) col_next = col_reg - 7'd1;
              CMD_HOME: begin
                col_next = '0;
                row_next = '0;
              end
              default:  error_next = 1'b1;
            endcase
          end
          default: ;
        endcase
      end

      ST_WRITE: begin
        mem_we     = 1'b1;
        mem_wdata  = {arg0_reg, arg1_reg};
        state_next = ST_DONE;
`ifdef TEXT_SCROLL_EN
        attr_next  = arg0_reg;
`endif
        if (col_reg == 7'(COLS - 1)) begin
          col_next    = '0;
          advance_row = 1'b1;
        end else begin
          col_next = col_reg + 7'd1;
        end
      end

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_reg;
        mem_wdata = {arg0_reg, BLANK_CHAR};
`ifdef TEXT_SCROLL_EN
        attr_next = arg0_reg;
`endif
        if (cnt_reg == ADDR_W'(CELLS - 1)) begin
          col_next   = '0;
          row_next   = '0;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end

      // The address is held for two cycles. RAM data appears in RD_WAIT.
      ST_RD_ADDR: begin
        mem_addr   = arg_addr;
        state_next = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        mem_addr   = arg_addr;
        res0_next  = mem_rdata[7:0];
        res1_next  = mem_rdata[15:8];
        state_next = ST_DONE;
      end

`ifdef TEXT_SCROLL_EN
      // Each cell is copied up one row in two cycles: read the cell below, then write it here.
      ST_SCR_RD: begin
        mem_addr   = cnt_reg + ADDR_W'(COLS);
        state_next = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_reg;
        mem_wdata = mem_rdata;
        cnt_next  = cnt_reg + ADDR_W'(1);
        if (cnt_reg == ADDR_W'(SCROLL_CELLS - 1)) state_next = ST_SCR_CLR;
        else state_next = ST_SCR_RD;
      end

      // cnt continues from the first cell of the last row through the end of the screen.
      ST_SCR_CLR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_reg;
        mem_wdata = {attr_reg, BLANK_CHAR};
        if (cnt_reg == ADDR_W'(CELLS - 1)) state_next = ST_DONE;
        else cnt_next = cnt_reg + ADDR_W'(1);
      end
`endif

      default: state_next = ST_IDLE;
    endcase

    // End-of-screen handling overrides the plain row increment.
    if (advance_row) begin
      if (row_reg == 5'(ROWS - 1)) begin
`ifdef TEXT_SCROLL_EN
        cnt_next   = '0;
        state_next = ST_SCR_RD;
`else
        row_next   = '0;
`endif
      end else begin
        row_next = row_reg + 5'd1;
      end
    end
  end

  assign cpu.instruction_busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign cpu.instruction_finished = (state_reg == ST_DONE);
  assign cpu.instruction_error    = error_reg;
  assign cpu.result_0             = res0_reg;
  assign cpu.result_1             = res1_reg;
  assign cursor_col               = col_reg;
  assign cursor_row               = row_reg;
endmodule

// File: tb/tb_text_instruction_engine.sv
// ---------------------------------------------------------------------------
// tb_text_instruction_engine
// Bench for text_instruction_engine. The bench holds a behavioural model of
// the screen: a cell array, the cursor, the error flag and the results. For
// every opcode it compares the DUT writes, cursor, error, results and
// finished stretch against that model. It uses directed cases and a
// randomized opcode stream.
// ---------------------------------------------------------------------------
module tb_text_instruction_engine;
  import vga_text_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int FIN   = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  text_instruction_engine_if cpu_if ();

  text_instruction_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu        (cpu_if),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  // Text RAM with a registered read port.
  logic [15:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural screen model ----------------
  int          m_col, m_row;
  logic        m_err;
  logic [7:0]  m_res0, m_res1, m_attr;
  logic [15:0] m_ram [0:CELLS-1];
  int          exp_wa[$];
  logic [15:0] exp_wd[$];
  int          last_stale_fin;

  task automatic m_write_cell(input int a, input logic [15:0] d);
    m_ram[a] = d;
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic m_next_row();
    if (m_row == ROWS - 1) begin
`ifdef TEXT_SCROLL_EN
      for (int i = 0; i < COLS * (ROWS - 1); i++) m_write_cell(i, m_ram[i + COLS]);
      for (int i = COLS * (ROWS - 1); i < CELLS; i++) m_write_cell(i, {m_attr, 8'h20});
      m_row = ROWS - 1;
`else
      m_row = 0;
`endif
    end else begin
      m_row++;
    end
  endtask

  task automatic m_apply(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                         output bit valid, output int exp_busy);
    bit in_range;
    exp_wa.delete();
    exp_wd.delete();
    exp_busy = -1;
    valid = (op <= 8'h04);
    in_range = (int'(a0) < COLS) && (int'(a1) < ROWS);
    if (valid) begin
      m_err = 1'b0;
      case (op)
        8'h00: begin
          m_write_cell(m_row * COLS + m_col, {a0, a1});
          m_attr = a0;
          if (m_col == COLS - 1) begin
            m_col = 0;
            m_next_row();
          end else m_col++;
        end
        8'h01: begin
          if (in_range) begin m_col = a0; m_row = a1; end
          else m_err = 1'b1;
        end
        8'h02: begin
          for (int i = 0; i < CELLS; i++) m_write_cell(i, {a0, 8'h20});
          m_attr = a0;
          m_col = 0;
          m_row = 0;
          exp_busy = CELLS + 1;
        end
        8'h03: begin
          if (in_range) begin
            m_res0 = m_ram[a1 * COLS + a0][7:0];
            m_res1 = m_ram[a1 * COLS + a0][15:8];
          end else m_err = 1'b1;
        end
        default: begin
          case (a0)
            8'h0D: m_col = 0;
            8'h0A: m_next_row();
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin m_col = 0; m_row = 0; end
            default: m_err = 1'b1;
          endcase
        end
      endcase
    end
  endtask

  // Issue one opcode and follow it to completion. Then compare against the model.
  task automatic run_op(input string name, input logic [7:0] op, input logic [7:0] a0,
                        input logic [7:0] a1, input bit early = 1'b0);
    bit          valid, seen, done;
    int          exp_busy, busy_n, fin_n, stale, bad;
    int          act_wa[$];
    logic [15:0] act_wd[$];
    m_apply(op, a0, a1, valid, exp_busy);
    seen = 0; done = 0; busy_n = 0; fin_n = 0; stale = 0; bad = 0;
    cpu_if.instruction = op;
    cpu_if.arg0 = a0;
    cpu_if.arg1 = a1;
    cpu_if.instruction_start = 1'b1;
    for (int cyc = 0; cyc < 9000; cyc++) begin
      @(negedge clk);
      if (cyc == 5) cpu_if.instruction_start = 1'b0;
      if (mem_we) begin
        act_wa.push_back(int'(mem_addr));
        act_wd.push_back(mem_wdata);
      end
      if (cpu_if.instruction_busy) begin
        busy_n++;
        seen = 1;
      end else if (cpu_if.instruction_finished) begin
        if (seen) fin_n++;
        else stale++;
      end
      if (seen && !cpu_if.instruction_busy && !cpu_if.instruction_finished) begin done = 1; break; end
      if (early && fin_n == 4) begin done = 1; break; end
      if (!valid && cyc >= 40) begin done = 1; break; end
    end
    cpu_if.instruction_start = 1'b0;
    last_stale_fin = stale;

    check_value({name, "/completed"}, 32'(done), 32'd1);
    if (valid) begin
      check_value({name, "/busy_seen"}, 32'(seen), 32'd1);
      if (exp_busy >= 0) check_value({name, "/busy_len"}, busy_n, exp_busy);
      if (!early) check_value({name, "/fin_len"}, fin_n, FIN);
    end else begin
      check_value({name, "/busy_len"}, busy_n, 0);
      check_value({name, "/fin_len"}, fin_n + stale, 0);
    end
    check_value({name, "/n_writes"}, act_wa.size(), exp_wa.size());
    for (int i = 0; i < act_wa.size() && i < exp_wa.size(); i++)
      if (act_wa[i] != exp_wa[i] || act_wd[i] !== exp_wd[i]) bad++;
    check_value({name, "/bad_writes"}, bad, 0);
    check_value({name, "/col"}, cursor_col, m_col);
    check_value({name, "/row"}, cursor_row, m_row);
    check_value({name, "/error"}, cpu_if.instruction_error, m_err);
    check_value({name, "/result_0"}, cpu_if.result_0, m_res0);
    check_value({name, "/result_1"}, cpu_if.result_1, m_res1);
    $display("op %-12s %02h %02h %02h -> col %0d row %0d err %0d res %02h/%02h busy %0d fin %0d writes %0d",
             name, op, a0, a1, cursor_col, cursor_row, cpu_if.instruction_error,
             cpu_if.result_1, cpu_if.result_0, busy_n, fin_n, act_wa.size());
  endtask

  initial begin
    logic [7:0] op, a0, a1;
    int         pick;
    cpu_if.instruction = '0;
    cpu_if.arg0 = '0;
    cpu_if.arg1 = '0;
    cpu_if.instruction_start = 1'b0;
    m_col = 0; m_row = 0; m_err = 0; m_res0 = '0; m_res1 = '0; m_attr = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst/busy", cpu_if.instruction_busy, 0);
    check_value("rst/finished", cpu_if.instruction_finished, 0);
    check_value("rst/error", cpu_if.instruction_error, 0);
    check_value("rst/result_0", cpu_if.result_0, 0);
    check_value("rst/result_1", cpu_if.result_1, 0);
    check_value("rst/mem_we", mem_we, 0);
    check_value("rst/mem_addr", mem_addr, 0);
    check_value("rst/cursor", {cursor_row, cursor_col}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    run_op("clear", OP_TEXT_CLEAR, 8'h07, 8'h00);
    run_op("pos_5_2", OP_TEXT_POSITION, 8'd5, 8'd2);
    run_op("write_A", OP_TEXT_WRITE, 8'h1F, 8'h41);
    run_op("get_5_2", OP_GET_TEXT_AT, 8'd5, 8'd2);
    run_op("pos_bad", OP_TEXT_POSITION, 8'd80, 8'd0);
    run_op("cmd_cr", OP_TEXT_COMMAND, CMD_CR, 8'h00);
    run_op("get_bad", OP_GET_TEXT_AT, 8'd0, 8'd30);
    run_op("pos_79_29", OP_TEXT_POSITION, 8'd79, 8'd29);
    run_op("write_wrap", OP_TEXT_WRITE, 8'h2E, 8'h5A);
    run_op("cmd_bs0", OP_TEXT_COMMAND, CMD_BS, 8'h00);
    run_op("cmd_bad", OP_TEXT_COMMAND, 8'h55, 8'h00);
    run_op("bad_opcode", 8'h10, 8'h00, 8'h00);
    run_op("pos_0_29", OP_TEXT_POSITION, 8'd0, 8'd29);
    run_op("cmd_lf_last", OP_TEXT_COMMAND, CMD_LF, 8'h00);

    // A new start during the finished stretch cuts the stretch short.
    run_op("write_early", OP_TEXT_WRITE, 8'h1E, 8'h42, 1'b1);
    run_op("pos_cut", OP_TEXT_POSITION, 8'd10, 8'd10);
    check_value("stretch_cut", 32'((4 + last_stale_fin) < FIN), 32'd1);

    // Randomized opcode stream
    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 19);
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      if (pick <= 6) op = OP_TEXT_WRITE;
      else if (pick <= 10) begin
        op = OP_TEXT_POSITION;
        a0 = 8'($urandom_range(70, 84));
        a1 = 8'($urandom_range(0, 32));
      end else if (pick <= 14) begin
        op = OP_GET_TEXT_AT;
        a0 = 8'($urandom_range(0, 82));
        a1 = 8'($urandom_range(0, 31));
      end else if (pick <= 18) begin
        op = OP_TEXT_COMMAND;
        case ($urandom_range(0, 4))
          0: a0 = CMD_CR;
          1: a0 = CMD_LF;
          2: a0 = CMD_BS;
          3: a0 = CMD_HOME;
          default: ;
        endcase
      end else op = 8'($urandom_range(5, 255));
      run_op($sformatf("rnd%0d", n), op, a0, a1);
    end

    // Asynchronous reset in the middle of a CLEAR
    cpu_if.instruction = OP_TEXT_CLEAR;
    cpu_if.arg0 = 8'h33;
    cpu_if.instruction_start = 1'b1;
    repeat (6) @(negedge clk);
    cpu_if.instruction_start = 1'b0;
    repeat (100) @(negedge clk);
    check_value("rst_mid/busy_before", cpu_if.instruction_busy, 1);
    check_value("rst_mid/we_before", mem_we, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_value("rst_mid/mem_we", mem_we, 0);
    check_value("rst_mid/busy", cpu_if.instruction_busy, 0);
    check_value("rst_mid/finished", cpu_if.instruction_finished, 0);
    check_value("rst_mid/cursor", {cursor_row, cursor_col}, 0);
    $display("op %-12s async reset during clear -> we %0d busy %0d col %0d row %0d",
             "rst_mid", mem_we, cpu_if.instruction_busy, cursor_col, cursor_row);
    @(negedge clk);
    reset_n = 1'b1;
    m_col = 0; m_row = 0; m_err = 0; m_res0 = '0; m_res1 = '0; m_attr = '0;
    repeat (2) @(negedge clk);
    run_op("pos_after_rst", OP_TEXT_POSITION, 8'd3, 8'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
